// File: rtl/alu_operand_regfile.sv
// Register-file operand stage feeding a 32-bit combinational ALU.
// Runs a fixed FETCH/EXEC/WB sequence per start pulse and writes the
// ALU result back into the register file. Includes an IDLE-only
// external write port and a combinational debug read port.
module alu_operand_regfile #(
   parameter int unsigned DW = 32,
   parameter int unsigned AW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] R_Addr_A,
   input  logic [AW-1:0] R_Addr_B,
   input  logic [AW-1:0] W_Addr,
   input  logic [2:0]    OP_in,
   input  logic          we_ext,
   input  logic [AW-1:0] W_Addr_ext,
   input  logic [DW-1:0] W_Data_ext,
   input  logic [AW-1:0] R_Addr_D,
   output logic [DW-1:0] R_Data_D,
   output logic [DW-1:0] A,
   output logic [DW-1:0] B,
   output logic [2:0]    ALU_OP,
   input  logic [DW-1:0] F,
   input  logic          OF_in,
   input  logic          ZF_in,
   output logic          busy,
   output logic          done,
   output logic          OF,
   output logic          ZF
);

   localparam int unsigned NREG = 1 << AW;
   localparam int unsigned OPW  = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      FETCH = 2'b01,
      EXEC  = 2'b10,
      WB    = 2'b11
   } state_t;

   state_t           r_state;
   state_t           w_next_state;

   logic [DW-1:0]    r_regs [NREG];

   logic [AW-1:0]    r_ra;
   logic [AW-1:0]    r_rb;
   logic [AW-1:0]    r_rd;
   logic [OPW-1:0]   r_op;

   logic [DW-1:0]    r_a;
   logic [DW-1:0]    r_b;
   logic [OPW-1:0]   r_alu_op;

   logic [DW-1:0]    r_f;
   logic             r_of_cap;
   logic             r_zf_cap;
   logic             r_of;
   logic             r_zf;
   logic             r_done;
   logic             r_busy;

   logic             w_we;
   logic [AW-1:0]    w_waddr;
   logic [DW-1:0]    w_wdata;
   logic [DW-1:0]    w_rd_a;
   logic [DW-1:0]    w_rd_b;

   // Read ports; r0 always reads as zero
   assign w_rd_a   = (r_ra == '0)     ? '0 : r_regs[r_ra];
   assign w_rd_b   = (r_rb == '0)     ? '0 : r_regs[r_rb];
   assign R_Data_D = (R_Addr_D == '0) ? '0 : r_regs[R_Addr_D];

   assign A      = r_a;
   assign B      = r_b;
   assign ALU_OP = r_alu_op;
   assign busy   = r_busy;
   assign done   = r_done;
   assign OF     = r_of;
   assign ZF     = r_zf;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   // Next-state and register-file write selection
   always_comb begin
      w_next_state = r_state;
      w_we         = 1'b0;
      w_waddr      = '0;
      w_wdata      = '0;
      case (r_state)
         IDLE: begin
            if (start) w_next_state = FETCH;
            if (we_ext && (W_Addr_ext != '0)) begin
               w_we    = 1'b1;
               w_waddr = W_Addr_ext;
               w_wdata = W_Data_ext;
            end
         end
         FETCH: w_next_state = EXEC;
         EXEC:  w_next_state = WB;
         WB: begin
            w_next_state = IDLE;
            if (r_rd != '0) begin
               w_we    = 1'b1;
               w_waddr = r_rd;
               w_wdata = r_f;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Register array: cleared on reset, single write port
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREG; i++) r_regs[i] <= '0;
      end else if (w_we) begin
         r_regs[w_waddr] <= w_wdata;
      end
   end

   // Sequence datapath: address latch, operand issue, result capture, flags
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ra     <= '0;
         r_rb     <= '0;
         r_rd     <= '0;
         r_op     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_alu_op <= '0;
         r_f      <= '0;
         r_of_cap <= 1'b0;
         r_zf_cap <= 1'b0;
         r_of     <= 1'b0;
         r_zf     <= 1'b0;
         r_done   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_ra <= R_Addr_A;
                  r_rb <= R_Addr_B;
                  r_rd <= W_Addr;
                  r_op <= OP_in;
               end
            end
            FETCH: begin
               r_a      <= w_rd_a;
               r_b      <= w_rd_b;
               r_alu_op <= r_op;
            end
            EXEC: begin
               r_f      <= F;
               r_of_cap <= OF_in;
               r_zf_cap <= ZF_in;
            end
            WB: begin
               r_of <= r_of_cap;
               r_zf <= r_zf_cap;
            end
            default: ;
         endcase
         r_done <= (r_state == WB);
         r_busy <= (w_next_state != IDLE);
      end
   end

endmodule

// File: tb/tb_alu_operand_regfile.sv
// Directed bench for alu_operand_regfile with a behavioural ALU and a
// reference register-file model; per-sequence expectations go through a queue.
module tb_alu_operand_regfile;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;

   typedef struct packed {
      logic [31:0] f;
      logic        of;
      logic        zf;
   } res_t;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
      logic [4:0]  rd;
      logic [31:0] f;
      logic        of;
      logic        zf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [4:0]  R_Addr_A, R_Addr_B, W_Addr, W_Addr_ext, R_Addr_D;
   logic [2:0]  OP_in;
   logic        we_ext;
   logic [31:0] W_Data_ext;
   logic [31:0] R_Data_D, A, B, F;
   logic [2:0]  ALU_OP;
   logic        OF_in, ZF_in, busy, done, OF, ZF;

   logic [31:0] m [32];
   exp_t        exp_q [$];
   int          n_checks = 0;
   int          n_fails  = 0;

   alu_operand_regfile #(.DW(32), .AW(5)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B), .W_Addr(W_Addr), .OP_in(OP_in),
      .we_ext(we_ext), .W_Addr_ext(W_Addr_ext), .W_Data_ext(W_Data_ext),
      .R_Addr_D(R_Addr_D), .R_Data_D(R_Data_D),
      .A(A), .B(B), .ALU_OP(ALU_OP), .F(F), .OF_in(OF_in), .ZF_in(ZF_in),
      .busy(busy), .done(done), .OF(OF), .ZF(ZF)
   );

   always #5 clk = ~clk;

   function automatic res_t alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
      res_t r;
      r = '0;
      case (op)
         OP_ADD: begin r.f = a + b; r.of = (a[31] == b[31]) && (r.f[31] != a[31]); end
         OP_SUB: begin r.f = a - b; r.of = (a[31] != b[31]) && (r.f[31] != a[31]); end
         OP_AND: r.f = a & b;
         OP_OR:  r.f = a | b;
         OP_XOR: r.f = a ^ b;
         default: r.f = '0;
      endcase
      r.zf = (r.f == 32'd0);
      return r;
   endfunction

   // Behavioural ALU driven by the DUT's registered operands
   res_t alu_out;
   always_comb begin
      alu_out = alu(A, B, ALU_OP);
      F       = alu_out.f;
      OF_in   = alu_out.of;
      ZF_in   = alu_out.zf;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic dbg(input string tag, input logic [4:0] a);
      R_Addr_D = a;
      #1;
      chk(tag, R_Data_D, m[a]);
   endtask

   task automatic ext_write(input logic [4:0] a, input logic [31:0] d);
      we_ext = 1'b1; W_Addr_ext = a; W_Data_ext = d;
      @(negedge clk);
      we_ext = 1'b0;
      if (a != 5'd0) m[a] = d;
   endtask

   // One start sequence; optional same-cycle external write and busy-time junk
   task automatic run_seq(input string tag, input logic [4:0] ra, input logic [4:0] rb,
                          input logic [4:0] rd, input logic [2:0] op,
                          input bit ext, input logic [4:0] eaddr, input logic [31:0] edata,
                          input bit junk);
      exp_t e, got;
      res_t r;
      int   cnt;
      R_Addr_A = ra; R_Addr_B = rb; W_Addr = rd; OP_in = op; start = 1'b1;
      if (ext) begin
         we_ext = 1'b1; W_Addr_ext = eaddr; W_Data_ext = edata;
         if (eaddr != 5'd0) m[eaddr] = edata;
      end
      e.a = m[ra]; e.b = m[rb]; e.op = op; e.rd = rd;
      r = alu(e.a, e.b, op);
      e.f = r.f; e.of = r.of; e.zf = r.zf;
      exp_q.push_back(e);
      @(negedge clk);                               // edge k
      start = 1'b0; we_ext = 1'b0;
      if (junk) begin
         start = 1'b1; we_ext = 1'b1; W_Addr_ext = 5'd9; W_Data_ext = 32'hDEAD_BEEF;
         R_Addr_A = ~ra; R_Addr_B = ~rb; W_Addr = 5'd9; OP_in = ~op;
      end
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_done_low"}, 32'(done), 32'd0);
      @(negedge clk);                               // edge k+1
      chk({tag, "_A"}, A, e.a);
      chk({tag, "_B"}, B, e.b);
      chk({tag, "_OP"}, 32'(ALU_OP), 32'(e.op));
      cnt = 1;
      while (done !== 1'b1 && cnt < 8) begin
         @(negedge clk);
         cnt++;
      end
      start = 1'b0; we_ext = 1'b0;
      chk({tag, "_latency"}, 32'(cnt), 32'd3);
      chk({tag, "_busy_end"}, 32'(busy), 32'd0);
      if (exp_q.size() == 0) begin
         chk({tag, "_queue"}, 32'd0, 32'd1);
      end else begin
         got = exp_q.pop_front();
         if (got.rd != 5'd0) m[got.rd] = got.f;
         chk({tag, "_OF"}, 32'(OF), 32'(got.of));
         chk({tag, "_ZF"}, 32'(ZF), 32'(got.zf));
         dbg({tag, "_wb"}, got.rd);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 32; i++) m[i] = 32'd0;
      rst_n = 1'b0; start = 1'b0; we_ext = 1'b0;
      R_Addr_A = '0; R_Addr_B = '0; W_Addr = '0; OP_in = '0;
      W_Addr_ext = '0; W_Data_ext = '0; R_Addr_D = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Reset state
      chk("rst_A", A, 32'd0);
      chk("rst_B", B, 32'd0);
      chk("rst_OP", 32'(ALU_OP), 32'd0);
      chk("rst_OF", 32'(OF), 32'd0);
      chk("rst_ZF", 32'(ZF), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      for (int i = 0; i < 32; i++) begin
         dbg("rst_reg", 5'(i));
         @(negedge clk);
      end

      // 5 + 3 into r3
      ext_write(5'd1, 32'h0000_0005);
      ext_write(5'd2, 32'h0000_0003);
      dbg("pre_r1", 5'd1);
      run_seq("add53", 5'd1, 5'd2, 5'd3, OP_ADD, 1'b0, 5'd0, 32'd0, 1'b0);
      chk("add53_r3", m[3], 32'h0000_0008);
      @(negedge clk);

      // Signed overflow, then dependent back-to-back subtract
      ext_write(5'd1, 32'h7FFF_FFFF);
      ext_write(5'd2, 32'h0000_0001);
      run_seq("add_of", 5'd1, 5'd2, 5'd4, OP_ADD, 1'b0, 5'd0, 32'd0, 1'b0);
      chk("add_of_r4", m[4], 32'h8000_0000);
      run_seq("sub_z", 5'd4, 5'd4, 5'd5, OP_SUB, 1'b0, 5'd0, 32'd0, 1'b0);
      chk("sub_z_r5", m[5], 32'h0000_0000);

      // start/we_ext/address changes while busy are ignored
      run_seq("xor_junk", 5'd3, 5'd4, 5'd8, OP_XOR, 1'b0, 5'd0, 32'd0, 1'b1);
      @(negedge clk);
      chk("junk_idle_busy", 32'(busy), 32'd0);
      chk("junk_idle_done", 32'(done), 32'd0);
      dbg("junk_r9", 5'd9);
      run_seq("or_b2b", 5'd8, 5'd2, 5'd11, OP_OR, 1'b0, 5'd0, 32'd0, 1'b0);

      // External write to r0 is discarded
      ext_write(5'd0, 32'hFFFF_FFFF);
      dbg("ext_r0", 5'd0);
      chk("ext_r0_raw", R_Data_D, 32'd0);
      @(negedge clk);

      // Same-cycle external write to ra is seen by FETCH
      run_seq("ext_fwd", 5'd7, 5'd0, 5'd10, OP_ADD, 1'b1, 5'd7, 32'h1234_5678, 1'b0);
      chk("ext_fwd_A", m[10], 32'h1234_5678);
      @(negedge clk);

      // rd = 0: done pulses, nothing written; leaves ZF set
      run_seq("rd0", 5'd0, 5'd0, 5'd0, OP_SUB, 1'b0, 5'd0, 32'd0, 1'b0);
      @(negedge clk);
      for (int i = 0; i < 32; i++) begin
         dbg("rd0_reg", 5'(i));
         @(negedge clk);
      end

      // Reset during EXEC aborts the sequence
      ext_write(5'd6, 32'hAAAA_AAAA);
      dbg("pre_r6", 5'd6);
      R_Addr_A = 5'd6; R_Addr_B = 5'd6; W_Addr = 5'd6; OP_in = OP_ADD; start = 1'b1;
      @(negedge clk);                               // edge k: FETCH
      start = 1'b0;
      @(negedge clk);                               // edge k+1: EXEC
      chk("abort_A", A, 32'hAAAA_AAAA);
      rst_n = 1'b0;
      @(negedge clk);                               // edge k+2: reset
      rst_n = 1'b1;
      for (int i = 0; i < 32; i++) m[i] = 32'd0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_OF", 32'(OF), 32'd0);
      chk("abort_ZF", 32'(ZF), 32'd0);
      chk("abort_A0", A, 32'd0);
      for (int i = 0; i < 3; i++) begin
         chk("abort_nodone", 32'(done), 32'd0);
         @(negedge clk);
      end
      dbg("abort_r6", 5'd6);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
